// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the scoreboarded register file.
// Holds the default geometry (16-bit registers, 8 entries) and the index/data typedefs.
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int DEPTH          = 1 << DEFAULT_ADDR_W;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: one bit per register, marking a destination with an
// outstanding producer. A reserve sets a bit and a write clears it. When both
// target the same index on one edge, the reserve wins. The two query ports
// return the busy state as it will be after the current edge, so the parent
// can register it alongside the read data.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_selClr,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_selSet,
  input  logic [ADDR_W-1:0] i_selA,
  input  logic [ADDR_W-1:0] i_selB,
  output logic              o_nextBusyA,
  output logic              o_nextBusyB
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busyNext;

  // Next busy vector: clear for the writeback first, then set for the reserve.
  // The set comes last so that it wins on a shared index.
  always_comb begin
    w_busyNext = r_busy;
    if (i_clr) w_busyNext[i_selClr] = 1'b0;
    if (i_set) w_busyNext[i_selSet] = 1'b1;
  end

  // Commit the busy vector on the falling edge while enabled; reset drops all reservations.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else if (i_en) begin
      r_busy <= w_busyNext;
    end
  end

  assign o_nextBusyA = w_busyNext[i_selA];
  assign o_nextBusyB = w_busyNext[i_selB];

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with two registered read ports, one write port,
// same-edge write-to-read bypass and a per-register busy scoreboard for RAW
// hazard detection at issue. All state changes on the falling edge of i_clk.
// Optional build macro REG_FILE_ZERO_R0_EN hardwires index 0. With the macro
// defined, index 0 always reads 0 and is never busy, and writes and reserves
// to it are dropped.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_selA,
  input  logic [ADDR_W-1:0] i_selB,
  input  logic [ADDR_W-1:0] i_selD,
  input  logic [DATA_W-1:0] i_dataD,
  input  logic              i_rsv,
  input  logic [ADDR_W-1:0] i_selR,
  output logic [DATA_W-1:0] o_dataA,
  output logic [DATA_W-1:0] o_dataB,
  output logic              o_busyA,
  output logic              o_busyB
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_weEff;
  logic              w_rsvEff;
  logic [DATA_W-1:0] w_readA;
  logic [DATA_W-1:0] w_readB;
  logic              w_nextBusyA;
  logic              w_nextBusyB;

`ifdef REG_FILE_ZERO_R0_EN
  // Index 0 is hardwired: it is never written and never reserved, so it keeps
  // its reset value of zero. Its busy bit never sets, and the bypass cannot fire for it.
  assign w_weEff  = i_we  && (i_selD != '0);
  assign w_rsvEff = i_rsv && (i_selR != '0);
`else
  assign w_weEff  = i_we;
  assign w_rsvEff = i_rsv;
`endif

  assign w_readA = (w_weEff && (i_selD == i_selA)) ? i_dataD : r_regs[i_selA];
  assign w_readB = (w_weEff && (i_selD == i_selB)) ? i_dataD : r_regs[i_selB];

  reg_file_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_clr      (w_weEff),
    .i_selClr   (i_selD),
    .i_set      (w_rsvEff),
    .i_selSet   (i_selR),
    .i_selA     (i_selA),
    .i_selB     (i_selB),
    .o_nextBusyA(w_nextBusyA),
    .o_nextBusyB(w_nextBusyB)
  );

  // Writeback into the register array on the falling edge while enabled.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_en && w_weEff) begin
      r_regs[i_selD] <= i_dataD;
    end
  end

  // Register the read data (bypassed) and the post-edge busy flags; hold them while disabled.
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dataA <= '0;
      o_dataB <= '0;
      o_busyA <= 1'b0;
      o_busyB <= 1'b0;
    end else if (i_en) begin
      o_dataA <= w_readA;
      o_dataB <= w_readB;
      o_busyA <= w_nextBusyA;
      o_busyB <= w_nextBusyB;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised self-checking bench for reg_file_sb with a behavioural reference model.
// The bench honours REG_FILE_ZERO_R0_EN the same way the design does.
module tb_reg_file_sb;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int NREGS = 1 << AW;

  logic          clk;
  logic          rstN;
  logic          en;
  logic          we;
  logic [AW-1:0] selA;
  logic [AW-1:0] selB;
  logic [AW-1:0] selD;
  logic [DW-1:0] dataD;
  logic          rsv;
  logic [AW-1:0] selR;
  logic [DW-1:0] dataA;
  logic [DW-1:0] dataB;
  logic          busyA;
  logic          busyB;

  // Reference model state: register contents and busy flags, plus expected outputs.
  logic [DW-1:0] mRegs [NREGS];
  logic          mBusy [NREGS];
  logic [DW-1:0] expA;
  logic [DW-1:0] expB;
  logic          expBusyA;
  logic          expBusyB;

  int vectorCount = 0;
  int missCount   = 0;

  reg_file_sb #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .i_en   (en),
    .i_we   (we),
    .i_selA (selA),
    .i_selB (selB),
    .i_selD (selD),
    .i_dataD(dataD),
    .i_rsv  (rsv),
    .i_selR (selR),
    .o_dataA(dataA),
    .o_dataB(dataB),
    .o_busyA(busyA),
    .o_busyB(busyB)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Model reset: everything back to zero.
  task automatic modelReset();
    for (int i = 0; i < NREGS; i++) begin
      mRegs[i] = '0;
      mBusy[i] = 1'b0;
    end
    expA = '0;
    expB = '0;
    expBusyA = 1'b0;
    expBusyB = 1'b0;
  endtask

  // Model one enabled falling edge. The read ports see this edge's write, and
  // the busy flags reflect the clear and then the set. With en low, everything holds.
  task automatic modelEdge();
    logic doWrite;
    logic doReserve;
    if (en) begin
      doWrite   = we;
      doReserve = rsv;
`ifdef REG_FILE_ZERO_R0_EN
      if (selD == 0) doWrite = 1'b0;
      if (selR == 0) doReserve = 1'b0;
`endif
      if (doWrite) begin
        mRegs[selD] = dataD;
        mBusy[selD] = 1'b0;
      end
      if (doReserve) mBusy[selR] = 1'b1;
      expA     = mRegs[selA];
      expB     = mRegs[selB];
      expBusyA = mBusy[selA];
      expBusyB = mBusy[selB];
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_dataA"}, 32'(dataA), 32'(expA));
    checkOutput({tag, "_dataB"}, 32'(dataB), 32'(expB));
    checkOutput({tag, "_busyA"}, 32'(busyA), 32'(expBusyA));
    checkOutput({tag, "_busyB"}, 32'(busyB), 32'(expBusyB));
  endtask

  // Drive one set of inputs, let one falling edge pass, then compare against the model.
  task automatic applyStimulus(input string tag, input logic e, input logic w,
                               input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic [AW-1:0] d, input logic [DW-1:0] dd,
                               input logic r, input logic [AW-1:0] rr);
    en = e; we = w; selA = a; selB = b; selD = d; dataD = dd; rsv = r; selR = rr;
    @(negedge clk);
    modelEdge();
    #2;
    checkAll(tag);
  endtask

  // Pulse reset between edges. Outputs must clear immediately, not at the next edge.
  task automatic applyReset(input string tag);
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    #2;
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b0;
    en = 1'b0; we = 1'b0; selA = '0; selB = '0; selD = '0; dataD = '0; rsv = 1'b0; selR = '0;
    modelReset();
    #3;
    checkAll("rst");
    #9;
    rstN = 1'b1;

    // 1: read after reset
    applyStimulus("t1", 1, 0, 3, 7, 0, 16'h0000, 0, 0);
    checkOutput("t1_const", 32'(dataA), 32'h0);

    // 2: plain write then read, and same-edge bypass
    applyStimulus("t2w", 1, 1, 0, 1, 5, 16'hBEEF, 0, 0);
    applyStimulus("t2r", 1, 0, 5, 5, 0, 16'h0000, 0, 0);
    checkOutput("t2_r5", 32'(dataA), 32'hBEEF);
    applyStimulus("t2b", 1, 1, 2, 5, 2, 16'h1234, 0, 0);
    checkOutput("t2_bypass", 32'(dataA), 32'h1234);

    // 3: reserve, then a write clears busy
    applyStimulus("t3r", 1, 0, 0, 0, 0, 16'h0000, 1, 4);
    applyStimulus("t3q", 1, 0, 4, 0, 0, 16'h0000, 0, 0);
    checkOutput("t3_busy", 32'(busyA), 32'h1);
    applyStimulus("t3w", 1, 1, 4, 4, 4, 16'h00AA, 0, 0);
    checkOutput("t3_clr", 32'(busyA), 32'h0);
    checkOutput("t3_data", 32'(dataA), 32'h00AA);

    // 4: write and reserve the same index on one edge, reserve wins
    applyStimulus("t4", 1, 1, 0, 6, 6, 16'h5555, 1, 6);
    checkOutput("t4_data", 32'(dataB), 32'h5555);
    checkOutput("t4_busy", 32'(busyB), 32'h1);
    applyStimulus("t4again", 1, 0, 6, 6, 0, 16'h0000, 1, 6);

    // 5: disabled edge holds everything, then async reset clears reservations
    applyStimulus("t5pre", 1, 1, 6, 1, 1, 16'h1111, 0, 0);
    applyStimulus("t5off", 0, 1, 1, 1, 1, 16'hFFFF, 1, 3);
    applyStimulus("t5r1", 1, 0, 1, 6, 0, 16'h0000, 0, 0);
    checkOutput("t5_r1", 32'(dataA), 32'h1111);
    applyReset("t5rst");
    for (int i = 0; i < NREGS; i++)
      applyStimulus("t5scan", 1, 0, AW'(i), AW'(i), 0, 16'h0000, 0, 0);

    // 6: index 0 behaviour
    applyStimulus("t6w", 1, 1, 0, 0, 0, 16'hABCD, 0, 0);
`ifdef REG_FILE_ZERO_R0_EN
    checkOutput("t6_r0", 32'(dataA), 32'h0);
`else
    checkOutput("t6_r0", 32'(dataA), 32'hABCD);
`endif
    applyStimulus("t6r", 1, 0, 0, 0, 0, 16'h0000, 1, 0);
`ifdef REG_FILE_ZERO_R0_EN
    checkOutput("t6_busy0", 32'(busyA), 32'h0);
`else
    checkOutput("t6_busy0", 32'(busyA), 32'h1);
`endif

    // Random traffic, with occasional disabled edges and mid-run resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        applyReset("rndrst");
      end else begin
        applyStimulus("rnd",
                      $urandom_range(0, 9) != 0,
                      1'($urandom_range(0, 1)),
                      AW'($urandom), AW'($urandom), AW'($urandom),
                      DW'($urandom),
                      $urandom_range(0, 2) == 0,
                      AW'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the processor's 8x16 register file.
- Generalised width and depth.
- Two registered read ports and one write port.
- Write-to-read bypass in the same edge.
- Per-register busy scoreboard so the issue stage can detect RAW hazards against in-flight destinations.
- Sits between decode (read/reserve) and writeback (write/release).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register index width; depth = 2**ADDR_W

Ports:
i_clk  in  1  clock; all state updates on the falling edge
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  block enable; when low, all state and outputs hold
i_we  in  1  write enable for port D
i_selA  in  ADDR_W  read address A
i_selB  in  ADDR_W  read address B
i_selD  in  ADDR_W  write address D
i_dataD  in  DATA_W  write data
i_rsv  in  1  reserve request: mark i_selR busy
i_selR  in  ADDR_W  register to reserve
o_dataA  out  DATA_W  registered read data A
o_dataB  out  DATA_W  registered read data B
o_busyA  out  1  registered busy flag of i_selA
o_busyB  out  1  registered busy flag of i_selB

Behaviour:
Reset and enable
- i_rst_n low, asynchronous: all registers = 0, all busy bits = 0, o_dataA/o_dataB = 0, o_busyA/o_busyB = 0.
- Release is synchronous to the next falling edge.
- All updates happen on the falling edge of i_clk, and only when i_en = 1.
- i_en = 0: no write, no reserve, outputs hold their last values.

Write
- i_we = 1: regs[i_selD] <= i_dataD.
- busy[i_selD] is cleared by the write.

Read
- o_dataA <= (i_we && i_selD == i_selA) ? i_dataD : regs[i_selA]. Port B is identical.
- Latency: data is valid after the same falling edge on which the address is sampled.

Reserve
- i_rsv = 1: busy[i_selR] <= 1.
- Write and reserve to the same index in one edge: the data is written, and busy ends set (reserve wins; a new producer is outstanding).
- Reserve on an index that is already busy: no change, and no error.
- Write to an index that is not busy: normal write, busy stays 0.

Busy outputs
- o_busyA <= next-state busy[i_selA], i.e. after this edge's clear/set is applied. Port B is identical.
- Example: a write to selA in the same edge reports busy = 0 unless that index is also reserved in the same edge.

Other rules
- selA == selB: both ports return identical data and busy.
- Reset mid-operation clears all pending reservations; there is no replay.
- Address width exactly indexes the full depth, so there is no out-of-range case.

Optional Feature:
REG_FILE_ZERO_R0_EN
- Defined: index 0 is hardwired.
  - Reads return 0 and busy 0.
  - Writes to index 0 are discarded, including the bypass path.
  - Reserves of index 0 are ignored.
- Undefined: index 0 is an ordinary register.

Decomposition:
Package reg_file_pkg:
- DATA_W and ADDR_W defaults.
- reg_idx_t typedef (ADDR_W bits).
- reg_data_t typedef (DATA_W bits).
- DEPTH constant.

Sub-module reg_file_scoreboard:
- Holds the 2**ADDR_W busy-bit vector with set (selR/rsv) and clear (selD/we) inputs.
- Returns next-state busy for the two query indices.
- reg_file_sb instantiates it and registers its outputs.

Test Plan:
1. Reset, then read A=3, B=7 with en=1 -> o_dataA = o_dataB = 0, busy flags 0.
2. Write r5 = 0xBEEF, next edge read A=5 -> 0xBEEF. Same-edge write r2 = 0x1234 with selA=2 -> o_dataA = 0x1234 (bypass).
3. Reserve r4, next edge read A=4 -> o_busyA = 1. Write r4 = 0x00AA -> o_busyA = 0, o_dataA = 0x00AA.
4. Write r6 = 0x5555 and reserve r6 in the same edge, selB=6 -> o_dataB = 0x5555, o_busyB = 1.
5. en=0 with we=1, selD=1, dataD=0xFFFF -> r1 is unchanged and outputs hold. Assert i_rst_n low between edges -> outputs go to 0 immediately and all busy bits clear.
6. With REG_FILE_ZERO_R0_EN: write r0 = 0xABCD with selA=0 -> o_dataA = 0; reserve r0 -> o_busyA = 0. Without the macro: o_dataA = 0xABCD.
